display_arbiter: RTL and testbench

DISPLAY_ARBITER -- requirements
Module: display_arbiter

---
 rtl/display_arbiter.sv | 91 +++++++++
 tb/tb_display_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// Arbitrates the shared 7-segment display between IE01 and IE02.
// In: clk, rst_n, req_a, req_b, priorsel. Out: grant_a/b, disp_sel, disp_blank, owner_change.
module display_arbiter #(
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic priorsel,
  output logic grant_a,
  output logic grant_b,
  output logic disp_sel,
  output logic disp_blank,
  output logic owner_change
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_A  = 2'd1,
    GNT_B  = 2'd2,
    SWITCH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LOAD =
    CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic             in_grant;
  logic             enter;
  logic             hold_done;

  assign in_grant  = (state == GNT_A) |
                     (state == GNT_B);
  assign hold_done = (cnt == '0);
  // A grant entry only happens from IDLE or SWITCH.
  assign enter = ~in_grant &
                 ((state_d == GNT_A) |
                  (state_d == GNT_B));

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, SWITCH: begin
        if (req_a & (~req_b | ~priorsel))
          state_d = GNT_A;
        else if (req_b)
          state_d = GNT_B;
        else
          state_d = IDLE;
      end
      GNT_A: begin
        if (~req_a |
            (req_b & priorsel & hold_done))
          state_d = SWITCH;
      end
      GNT_B: begin
        if (~req_b |
            (req_a & ~priorsel & hold_done))
          state_d = SWITCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      disp_sel     <= 1'b0;
      owner_change <= 1'b0;
    end else begin
      state        <= state_d;
      owner_change <= enter;
      if (enter) begin
        cnt      <= LOAD;
        disp_sel <= (state_d == GNT_B);
      end else if (in_grant && !hold_done) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign grant_a    = (state == GNT_A);
  assign grant_b    = (state == GNT_B);
  assign disp_blank = ~in_grant;

endmodule

// File: tb/tb_display_arbiter.sv
// Randomized and directed bench for display_arbiter.
// Compares DUT against a grant-ownership model each cycle.
module tb_display_arbiter;

  localparam int H = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_a = 1'b0;
  logic req_b = 1'b0;
  logic priorsel = 1'b0;
  logic grant_a, grant_b;
  logic disp_sel, disp_blank;
  logic owner_change;

  int vecs = 0;
  int errs = 0;

  // model: 0 = nobody, 1 = IE01, 2 = IE02
  int m_own = 0;
  int m_held = 0;
  bit m_sel = 1'b0;
  bit m_oc = 1'b0;

  display_arbiter #(
    .HOLD_CYCLES(H),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_a(req_a),
    .req_b(req_b),
    .priorsel(priorsel),
    .grant_a(grant_a),
    .grant_b(grant_b),
    .disp_sel(disp_sel),
    .disp_blank(disp_blank),
    .owner_change(owner_change)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] exp_vec();
    return {m_own == 1, m_own == 2, m_sel,
            m_own == 0, m_oc};
  endfunction

  function automatic logic [4:0] dut_vec();
    return {grant_a, grant_b, disp_sel,
            disp_blank, owner_change};
  endfunction

  task automatic model_reset();
    m_own = 0;
    m_held = 0;
    m_sel = 1'b0;
    m_oc = 1'b0;
  endtask

  // Ownership view: who holds the display and for how long.
  task automatic model_edge();
    int win;
    m_oc = 1'b0;
    if (m_own == 1) begin
      if (!req_a ||
          (req_b && priorsel && m_held >= H))
        m_own = 0;
      else
        m_held++;
    end else if (m_own == 2) begin
      if (!req_b ||
          (req_a && !priorsel && m_held >= H))
        m_own = 0;
      else
        m_held++;
    end else begin
      win = 0;
      if (req_a && req_b) win = priorsel ? 2 : 1;
      else if (req_a) win = 1;
      else if (req_b) win = 2;
      if (win != 0) begin
        m_own = win;
        m_held = 1;
        m_sel = (win == 2);
        m_oc = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic drive(input bit a, input bit b,
                       input bit p);
    req_a = a;
    req_b = b;
    priorsel = p;
  endtask

  task automatic test_reset();
    #2;
    vecs++;
    if (dut_vec() !== 5'b00010) begin
      $display("FAIL reset_async got %b want %b",
               dut_vec(), 5'b00010);
      errs++;
    end
    drive(1, 0, 0);
    step();
    vecs++;
    if (dut_vec() !== 5'b00010) begin
      $display("FAIL reset_hold got %b want %b",
               dut_vec(), 5'b00010);
      errs++;
    end
    drive(0, 0, 0);
    rst_n = 1'b1;
    step();
    vecs++;
    if (dut_vec() !== exp_vec()) begin
      $display("FAIL reset_idle got %b want %b",
               dut_vec(), exp_vec());
      errs++;
    end
  endtask

  task automatic test_single_a();
    drive(1, 0, 0);
    step();
    vecs++;
    if (dut_vec() !== 5'b10001) begin
      $display("FAIL single_a_grant got %b want %b",
               dut_vec(), 5'b10001);
      errs++;
    end
    step();
    vecs++;
    if (dut_vec() !== 5'b10000) begin
      $display("FAIL single_a_oc got %b want %b",
               dut_vec(), 5'b10000);
      errs++;
    end
    drive(0, 0, 0);
    step();
    step();
    vecs++;
    if (dut_vec() !== 5'b00010) begin
      $display("FAIL single_a_idle got %b want %b",
               dut_vec(), 5'b00010);
      errs++;
    end
  endtask

  task automatic test_simultaneous();
    logic [4:0] want [2];
    want[0] = 5'b10001;
    want[1] = 5'b01101;
    for (int p = 1; p >= 0; p--) begin
      drive(1, 1, p[0]);
      step();
      vecs++;
      if (dut_vec() !== want[p] ||
          dut_vec() !== exp_vec()) begin
        $display("FAIL simul_p%0d got %b want %b",
                 p, dut_vec(), want[p]);
        errs++;
      end
      drive(0, 0, p[0]);
      step();
      step();
    end
  endtask

  task automatic test_preempt();
    int n;
    drive(1, 0, 1);
    step();
    n = grant_a ? 1 : 0;
    step();
    if (grant_a) n++;
    req_b = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      vecs++;
      if (dut_vec() !== exp_vec()) begin
        $display("FAIL preempt_step got %b want %b",
                 dut_vec(), exp_vec());
        errs++;
      end
      if (!grant_a) break;
      n++;
    end
    vecs++;
    if (n !== H) begin
      $display("FAIL preempt_hold got %0d want %0d",
               n, H);
      errs++;
    end
    vecs++;
    if ({grant_a, grant_b, disp_blank} !== 3'b001) begin
      $display("FAIL preempt_switch got %b want 001",
               {grant_a, grant_b, disp_blank});
      errs++;
    end
    step();
    vecs++;
    if (dut_vec() !== 5'b01101) begin
      $display("FAIL preempt_gnt_b got %b want %b",
               dut_vec(), 5'b01101);
      errs++;
    end
    drive(0, 0, 0);
    step();
    step();
  endtask

  task automatic test_no_preempt();
    int held;
    drive(1, 1, 0);
    held = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (grant_a) held++;
    end
    vecs++;
    if (held !== 50) begin
      $display("FAIL no_preempt got %0d want 50",
               held);
      errs++;
    end
    req_a = 1'b0;
    step();
    vecs++;
    if (dut_vec() !== 5'b00010) begin
      $display("FAIL release_switch got %b want %b",
               dut_vec(), 5'b00010);
      errs++;
    end
    step();
    vecs++;
    if (dut_vec() !== 5'b01101) begin
      $display("FAIL release_gnt_b got %b want %b",
               dut_vec(), 5'b01101);
      errs++;
    end
  endtask

  task automatic test_async_reset();
    drive(0, 1, 0);
    step();
    step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vecs++;
    if (dut_vec() !== 5'b00010) begin
      $display("FAIL async_rst got %b want %b",
               dut_vec(), 5'b00010);
      errs++;
    end
    #1;
    rst_n = 1'b1;
    step();
    vecs++;
    if (dut_vec() !== 5'b01101 ||
        dut_vec() !== exp_vec()) begin
      $display("FAIL rst_regrant got %b want %b",
               dut_vec(), 5'b01101);
      errs++;
    end
    drive(0, 0, 0);
    step();
    step();
  endtask

  task automatic test_soak();
    bit pa, pb;
    int oc_n, entries;
    pa = 0;
    pb = 0;
    oc_n = 0;
    entries = 0;
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) < 10 ?
              priorsel : ~priorsel);
      step();
      vecs++;
      if (dut_vec() !== exp_vec()) begin
        $display("FAIL soak_%0d got %b want %b",
                 i, dut_vec(), exp_vec());
        errs++;
      end
      vecs++;
      if ((grant_a && grant_b) ||
          (pa && grant_b) || (pb && grant_a)) begin
        $display("FAIL soak_overlap_%0d got %b%b%b%b",
                 i, pa, pb, grant_a, grant_b);
        errs++;
      end
      if (owner_change) oc_n++;
      if ((grant_a && !pa) || (grant_b && !pb))
        entries++;
      pa = grant_a;
      pb = grant_b;
    end
    vecs++;
    if (oc_n !== entries) begin
      $display("FAIL soak_oc_count got %0d want %0d",
               oc_n, entries);
      errs++;
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_simultaneous();
    test_preempt();
    test_no_preempt();
    test_async_reset();
    test_soak();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
